// File: rtl/moosic_pkg.sv
// Shared widths and types for the moosic PWM audio output stage.
package moosic_pkg;
   localparam int SAMPLE_W = 8;
   localparam int DIV_W    = 4;

   typedef logic [SAMPLE_W-1:0] sample_t;
   typedef logic [DIV_W-1:0]    div_t;

   localparam sample_t SAMPLE_MAX = '1;
endpackage

// File: rtl/moosic_tick_gen.sv
// Tick prescaler: one tick every div_i+1 clk cycles, parked at zero while disabled.
module moosic_tick_gen
   import moosic_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  div_t div_i,
   output logic tick
);

   div_t presc_q, presc_d;

   // Equality compare so a shrinking div_i lets the count run up to max and wrap.
   always_comb begin
      presc_d = presc_q;
      if (!ena) begin
         presc_d = '0;
      end else if (presc_q == div_i) begin
         presc_d = '0;
      end else begin
         presc_d = div_t'(presc_q + 1'b1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

   assign tick = ena && (presc_q == div_i);

endmodule

// File: rtl/moosic_pwm_out.sv
// PWM audio output: one-entry sample buffer, period counter, duty comparator, underrun flag.
module moosic_pwm_out
   import moosic_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    ena,
   input  div_t    div_i,
   input  sample_t sample_i,
   input  logic    sample_valid_i,
   output logic    sample_ready_o,
   output logic    period_start_o,
   output logic    underrun_o,
   input  logic    underrun_clr_i,
   output logic    pwm_o
);

   sample_t cnt_q, cnt_d;
   sample_t active_q, active_d;
   sample_t pend_q, pend_d;
   logic    pend_full_q, pend_full_d;
   logic    pwm_q, pwm_d;
   logic    pstart_q, pstart_d;
   logic    unr_q, unr_d;
   logic    tick;
   logic    wrap;
   logic    accept;

   moosic_tick_gen u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .div_i (div_i),
      .tick  (tick)
   );

   assign wrap           = tick && (cnt_q == SAMPLE_MAX);
   // The wrap frees the pending slot in the same cycle, so a full buffer still accepts then.
   assign sample_ready_o = !pend_full_q || wrap;
   assign accept         = sample_valid_i && sample_ready_o;

   always_comb begin
      cnt_d       = cnt_q;
      active_d    = active_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      unr_d       = unr_q;
      pstart_d    = wrap;
      pwm_d       = ena && (cnt_q < active_q);

      if (!ena) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = sample_t'(cnt_q + 1'b1);
      end

      if (wrap && pend_full_q) begin
         active_d    = pend_q;
         pend_full_d = 1'b0;
      end
      if (accept) begin
         pend_d      = sample_i;
         pend_full_d = 1'b1;
      end

      if (underrun_clr_i) begin
         unr_d = 1'b0;
      end
      if (wrap && !pend_full_q) begin
         unr_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         active_q    <= '0;
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         pwm_q       <= 1'b0;
         pstart_q    <= 1'b0;
         unr_q       <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         active_q    <= active_d;
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         pwm_q       <= pwm_d;
         pstart_q    <= pstart_d;
         unr_q       <= unr_d;
      end
   end

   assign pwm_o          = pwm_q;
   assign period_start_o = pstart_q;
   assign underrun_o     = unr_q;

endmodule

// File: tb/tb_moosic_pwm_out.sv
// Directed bench for moosic_pwm_out: period timing, duty counts, handshake, underrun, reset and enable.
module tb_moosic_pwm_out;
   import moosic_pkg::*;

   logic    clk = 1'b0;
   logic    rst_n = 1'b0;
   logic    ena = 1'b1;
   div_t    div_i = '0;
   sample_t sample_i = '0;
   logic    sample_valid_i = 1'b0;
   logic    underrun_clr_i = 1'b0;
   logic    sample_ready_o;
   logic    period_start_o;
   logic    underrun_o;
   logic    pwm_o;

   int n_chk = 0;
   int n_fail = 0;

   moosic_pwm_out dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ena            (ena),
      .div_i          (div_i),
      .sample_i       (sample_i),
      .sample_valid_i (sample_valid_i),
      .sample_ready_o (sample_ready_o),
      .period_start_o (period_start_o),
      .underrun_o     (underrun_o),
      .underrun_clr_i (underrun_clr_i),
      .pwm_o          (pwm_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Runs from one period_start pulse to the next, counting cycles and pwm-high cycles.
   task automatic run_period(input string tag, input bit push_en, input sample_t push_val,
                             input int clr_at, input int exp_len, input int exp_highs);
      int cnt = 0;
      int highs = 0;
      do begin
         sample_valid_i = push_en && (cnt == 0);
         sample_i       = push_val;
         underrun_clr_i = ((cnt + 1) == clr_at);
         step();
         cnt++;
         if (pwm_o) highs++;
         if (cnt == 1) check_eq({tag, "_ps_pulse"}, 32'(period_start_o), 0);
      end while (!(period_start_o && cnt > 1) && cnt < exp_len + 64);
      sample_valid_i = 1'b0;
      underrun_clr_i = 1'b0;
      check_eq({tag, "_len"}, 32'(cnt), 32'(exp_len));
      check_eq({tag, "_highs"}, 32'(highs), 32'(exp_highs));
   endtask

   initial begin
      int cnt;
      int rdy_step;
      int npulse;
      int highs;

      // reset held with clock running
      repeat (3) @(negedge clk);
      check_eq("rst_pwm", 32'(pwm_o), 0);
      check_eq("rst_ps", 32'(period_start_o), 0);
      check_eq("rst_unr", 32'(underrun_o), 0);
      check_eq("rst_ready", 32'(sample_ready_o), 1);
      rst_n = 1'b1;

      run_period("boot", 1'b0, 8'h00, 0, 256, 0);
      check_eq("boot_unr", 32'(underrun_o), 1);
      check_eq("boot_ready", 32'(sample_ready_o), 1);

      run_period("p1", 1'b1, 8'h80, 1, 256, 0);
      check_eq("p1_unr", 32'(underrun_o), 0);
      run_period("p2", 1'b1, 8'h80, 0, 256, 128);
      check_eq("p2_unr", 32'(underrun_o), 0);
      run_period("p3", 1'b1, 8'h00, 0, 256, 128);
      run_period("p4", 1'b1, 8'hFF, 0, 256, 0);
      check_eq("p4_unr", 32'(underrun_o), 0);

      div_i = 4'd3;
      run_period("p5_div3", 1'b0, 8'h00, 0, 1024, 1020);
      check_eq("p5_unr", 32'(underrun_o), 1);

      // backpressure: second push stalls until the wrap cycle
      div_i = 4'd0;
      underrun_clr_i = 1'b1;
      step();
      underrun_clr_i = 1'b0;
      repeat (99) step();
      cnt = 100;
      sample_valid_i = 1'b1;
      sample_i = 8'h10;
      step();
      cnt++;
      check_eq("bp_ready_low", 32'(sample_ready_o), 0);
      check_eq("bp_unr_clr", 32'(underrun_o), 0);
      sample_i = 8'h20;
      rdy_step = -1;
      do begin
         if (sample_ready_o && rdy_step < 0) rdy_step = cnt;
         step();
         cnt++;
      end while (!period_start_o && cnt < 400);
      sample_valid_i = 1'b0;
      check_eq("bp_len", 32'(cnt), 256);
      check_eq("bp_ready_step", 32'(rdy_step), 255);
      check_eq("bp_unr", 32'(underrun_o), 0);

      run_period("p6", 1'b0, 8'h00, 0, 256, 16);
      check_eq("p6_unr", 32'(underrun_o), 0);
      run_period("p7", 1'b1, 8'h40, 0, 256, 32);
      check_eq("p7_unr", 32'(underrun_o), 0);
      run_period("p8", 1'b0, 8'h00, 256, 256, 64);
      check_eq("clr_at_wrap_unr", 32'(underrun_o), 1);

      underrun_clr_i = 1'b1;
      step();
      underrun_clr_i = 1'b0;
      check_eq("clr_mid_unr", 32'(underrun_o), 0);

      // async reset while pwm is high and a sample is buffered
      sample_valid_i = 1'b1;
      sample_i = 8'h77;
      step();
      sample_valid_i = 1'b0;
      check_eq("ar_pre_ready", 32'(sample_ready_o), 0);
      check_eq("ar_pre_pwm", 32'(pwm_o), 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("ar_pwm_async", 32'(pwm_o), 0);
      check_eq("ar_ready_async", 32'(sample_ready_o), 1);
      @(negedge clk);
      rst_n = 1'b1;
      check_eq("ar_post_ready", 32'(sample_ready_o), 1);
      check_eq("ar_post_pwm", 32'(pwm_o), 0);
      check_eq("ar_post_unr", 32'(underrun_o), 0);

      run_period("rst_p", 1'b1, 8'hFF, 0, 256, 0);
      check_eq("rst_p_unr", 32'(underrun_o), 0);

      // enable drop mid-period
      repeat (10) step();
      check_eq("ena_pwm_on", 32'(pwm_o), 1);
      ena = 1'b0;
      step();
      check_eq("ena_off_pwm", 32'(pwm_o), 0);
      sample_valid_i = 1'b1;
      sample_i = 8'h30;
      step();
      sample_valid_i = 1'b0;
      check_eq("ena_off_buffered", 32'(sample_ready_o), 0);
      npulse = 0;
      highs = 0;
      repeat (300) begin
         step();
         if (period_start_o) npulse++;
         if (pwm_o) highs++;
      end
      check_eq("ena_off_pulses", 32'(npulse), 0);
      check_eq("ena_off_highs", 32'(highs), 0);
      check_eq("ena_off_unr", 32'(underrun_o), 0);

      ena = 1'b1;
      run_period("ena_p1", 1'b0, 8'h00, 0, 256, 255);
      check_eq("ena_p1_unr", 32'(underrun_o), 0);
      run_period("ena_p2", 1'b0, 8'h00, 0, 256, 48);
      check_eq("ena_p2_unr", 32'(underrun_o), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/moosic_pwm_out.md
Name: moosic_pwm_out

Overview:
- Audio output stage directly downstream of the moosic sample source; consumes its 8-bit unsigned sample stream.
- Converts each sample into a fixed-period PWM waveform on one output pin, for an external RC filter/speaker.
- Contains a one-entry sample buffer with valid/ready handshake, a programmable tick prescaler, a period counter, and an underrun flag.

Parameters:
- SAMPLE_W, 8, sample and PWM counter width; PWM period = 2^SAMPLE_W ticks.
- DIV_W, 4, width of the prescaler divide input.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ena  in  1  block enable.
- div_i  in  DIV_W  prescaler setting; one tick every div_i+1 clk cycles.
- sample_i  in  SAMPLE_W  unsigned sample, duty = sample/2^SAMPLE_W.
- sample_valid_i  in  1  sample_i valid.
- sample_ready_o  out  1  buffer can accept a sample this cycle.
- period_start_o  out  1  one-cycle pulse when a new PWM period begins (sample request to upstream).
- underrun_o  out  1  sticky: a period started with no buffered sample.
- underrun_clr_i  in  1  clears underrun_o.
- pwm_o  out  1  registered PWM output.

Behaviour:
- Reset (rst_n=0, async): prescaler=0, counter=0, active=0, pending_full=0, pwm_o=0, period_start_o=0, underrun_o=0. Reset mid-period discards both buffered samples immediately.
- tick: prescaler counts 0..div_i; tick=1 in the cycle prescaler==div_i, then prescaler returns to 0. With div_i=0, tick=1 every cycle. A div_i change takes effect at the next compare; if prescaler>div_i, it counts up to its max and wraps to 0.
- counter: increments by 1 on tick, wraps 2^SAMPLE_W-1 -> 0.
- wrap = tick && counter==max. On wrap:
  - If pending_full, active<=pending and pending_full<=0.
  - Otherwise active holds and underrun_o<=1.
  - period_start_o<=1 in the next cycle, for one cycle only.
- Handshake:
  - sample_ready_o = !pending_full || wrap. It has no combinational dependence on sample_valid_i.
  - Accept = sample_valid_i && sample_ready_o; pending<=sample_i and pending_full<=1.
  - Accept in the same cycle as wrap: active takes the old pending, and the new sample is stored in pending (pending_full stays 1).
  - When pending_full=0 and wrap: active holds (underrun), and the accepted sample goes to pending.
- pwm_o is registered: pwm_o <= ena && (counter < active), one cycle latency from counter.
  - active=0 gives constant 0.
  - active=max gives high for 2^SAMPLE_W-1 of 2^SAMPLE_W ticks.
- underrun_o: set on an underrun wrap; cleared by underrun_clr_i; set wins if both occur in the same cycle.
- ena=0:
  - prescaler and counter are held at 0; no ticks, no wraps, no period_start_o, no underrun.
  - pwm_o<=0.
  - Handshake still works: one sample may be buffered.
  - active is retained.
- ena rising: the counting period begins from counter=0 using the existing active value. The first wrap loads pending.
- No X on outputs after reset; all state in one clock domain.

Decomposition:
- Shared package moosic_pkg:
  - SAMPLE_W and DIV_W constants.
  - typedef sample_t (logic [SAMPLE_W-1:0]).
  - typedef div_t.
- One sub-module, moosic_tick_gen: the prescaler (inputs clk, rst_n, ena, div_i; output tick).
- The buffer, counter and comparator stay in the top level.

Test Plan:
- Reset/idle: hold rst_n=0, then release with ena=1, div_i=0, no samples -> pwm_o=0 throughout. First period_start_o arrives 1 cycle after cycle 256 of counting; underrun_o=1 after the first wrap.
- Half duty: div_i=0; push 0x80 before the first wrap -> from the second period on, pwm_o is high for exactly 128 cycles then low 128, each period_start_o is 256 cycles apart, and underrun_o stays 0 while a sample is pushed per period.
- Extremes and prescale: push 0x00 -> pwm_o constant 0. Then div_i=3, push 0xFF -> pwm_o high 1020 cycles, low 4 cycles, period 1024 cycles.
- Backpressure: push 0x10 and 0x20 back-to-back mid-period -> second push stalls with sample_ready_o=0 until wrap. At wrap, active=0x10 and pending=0x20 in the same cycle. Next period duty is 16 ticks, the one after is 32.
- Underrun/clear: stop pushing after 0x40 -> active stays 0x40 and underrun_o=1 after the next wrap. Assert underrun_clr_i in a wrap cycle with no pending sample -> underrun_o remains 1 (set wins). Clear in a non-wrap cycle -> underrun_o=0.
- Async reset and enable:
  - Assert rst_n=0 mid-period while pwm_o=1 -> pwm_o=0 immediately (no clock edge needed), and sample_ready_o=1 after release.
  - Separately, ena=0 mid-period -> pwm_o=0 next cycle, counter frozen at 0, a sample is still accepted, then sample_ready_o=0.
